// File: rtl/dtw_pkg.sv
// Shared types and constants for the DTW result writer.
// State encoding, trailer tag and data-word width.
package dtw_pkg;

    localparam int WORD_W = 32;
    localparam logic [7:0] TRAILER_TAG = 8'hA5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_TRAILER
    } state_e;

    function automatic logic [WORD_W-1:0] trailer_word(
        input logic [15:0] n
    );
        return {TRAILER_TAG, 8'h00, n};
    endfunction

endpackage

// File: rtl/dtw_result_writer_if.sv
// Result-SRAM write port shared with the host-side arbiter.
// The master drives requests, the slave returns the grant.
interface dtw_result_writer_if #(
    parameter int ADDR_W = 10
) ();
    import dtw_pkg::*;

    logic              cen;
    logic              wen;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic              gnt;

    modport master (
        output cen, wen, addr, wdata,
        input  gnt
    );

    modport slave (
        input  cen, wen, addr, wdata,
        output gnt
    );
endinterface

// File: rtl/dtw_wr_fifo.sv
// Small synchronous FIFO buffering backtrace words ahead of the SRAM.
// Flush empties it in one cycle when a new record starts.
module dtw_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + (AW+1)'(1);
            if (pop)  rptr_d = rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wptr_q[AW-1:0]] <= din;
    end

    assign level = wptr_q - rptr_q;
    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (level == '0);
    assign dout  = mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/dtw_result_writer.sv
// Writes backtrace words to the result SRAM, then a length trailer.
// Pulses o_done when the trailer is accepted by the arbiter.
module dtw_result_writer
    import dtw_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 4,
    parameter int MAX_WORDS = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_bt_start,
    input  logic              i_valid,
    input  logic [WORD_W-1:0] i_data,
    input  logic              i_bt_end,
    dtw_result_writer_if.master sram,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_overflow
);
    localparam int LW = $clog2(DEPTH) + 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;

    logic              push, pop, full, empty;
    logic [LW-1:0]     level;
    logic [WORD_W-1:0] head;
    logic              req, acc, room, cen;

    dtw_wr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (i_bt_start),
        .push  (push),
        .pop   (pop),
        .din   (i_data),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (i_bt_start) begin
            state_d = S_RUN;
        end else begin
            unique case (state_q)
                S_IDLE:    state_d = S_IDLE;
                S_RUN:     if (i_bt_end)  state_d = S_DRAIN;
                S_DRAIN:   if (empty)     state_d = S_TRAILER;
                S_TRAILER: if (sram.gnt)  state_d = S_IDLE;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    // Capacity counts words already written plus words still queued.
    always_comb begin
        req    = (state_q == S_RUN || state_q == S_DRAIN) && !empty;
        acc    = req && sram.gnt;
        room   = (int'(cnt_q) + int'(level)) < MAX_WORDS;
        push   = (state_q == S_RUN) && i_valid && !full && room
                 && !i_bt_start;
        pop    = acc;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        if (i_bt_start) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else begin
            if (acc) cnt_d = cnt_q + ADDR_W'(1);
            if ((state_q == S_RUN) && i_valid && !push) ovf_d = 1'b1;
        end
        done_d = (state_q == S_TRAILER) && sram.gnt && !i_bt_start;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            done_q <= done_d;
        end
    end

    always_comb begin
        cen        = (state_q == S_TRAILER) || req;
        sram.cen   = cen;
        sram.wen   = cen;
        sram.addr  = ADDR_W'(BASE_ADDR) + cnt_q;
        sram.wdata = '0;
        if (state_q == S_TRAILER) sram.wdata = trailer_word(16'(cnt_q));
        else if (req)             sram.wdata = head;
        o_busy     = (state_q != S_IDLE);
        o_done     = done_q;
        o_overflow = ovf_q;
    end

endmodule
